// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection,
// flush/stall bubble insertion and a saturating bubble counter.
module id_ex_register #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            Stall,
   input  logic            Flush,
   input  logic            ID_Valid,
   input  logic [XLEN-1:0] ID_PC,
   input  logic [XLEN-1:0] ID_ReadData1,
   input  logic [XLEN-1:0] ID_ReadData2,
   input  logic [XLEN-1:0] ID_Imm,
   input  logic [4:0]      ID_Rs1,
   input  logic [4:0]      ID_Rs2,
   input  logic [4:0]      ID_Rd,
   input  logic [3:0]      ID_Funct,
   input  logic [1:0]      ID_ALUOp,
   input  logic [5:0]      ID_Ctrl,
   output logic            EX_Valid,
   output logic [XLEN-1:0] EX_PC,
   output logic [XLEN-1:0] EX_ReadData1,
   output logic [XLEN-1:0] EX_ReadData2,
   output logic [XLEN-1:0] EX_Imm,
   output logic [4:0]      EX_Rs1,
   output logic [4:0]      EX_Rs2,
   output logic [4:0]      EX_Rd,
   output logic [3:0]      EX_Funct,
   output logic [1:0]      EX_ALUOp,
   output logic [5:0]      EX_Ctrl,
   output logic            HazardStall,
   output logic [15:0]     BubbleCount
);

   // Ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc}
   localparam int C_MEMREAD = 3;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      funct;
      logic [1:0]      aluop;
      logic [5:0]      ctrl;
   } ex_t;

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_HOLD,
      ACT_BUBBLE
   } act_t;

   ex_t         r_ex;
   ex_t         w_load;
   act_t        w_act;
   logic        w_hazard;
   logic        w_rs_match;
   logic [15:0] r_bubbles;

   // Load-use hazard: EX holds a valid load whose Rd feeds the ID instruction
   always_comb begin
      w_rs_match = (r_ex.rd == ID_Rs1) | (r_ex.rd == ID_Rs2);
      w_hazard   = r_ex.valid
                 & r_ex.ctrl[C_MEMREAD]
                 & (r_ex.rd != 5'd0)
                 & ID_Valid
                 & w_rs_match;
   end

   // Image of the ID instruction; invalid slots carry no side effects
   always_comb begin
      w_load.valid = ID_Valid;
      w_load.pc    = ID_PC;
      w_load.rd1   = ID_ReadData1;
      w_load.rd2   = ID_ReadData2;
      w_load.imm   = ID_Imm;
      w_load.rs1   = ID_Rs1;
      w_load.rs2   = ID_Rs2;
      w_load.rd    = ID_Rd;
      w_load.funct = ID_Funct;
      w_load.aluop = ID_ALUOp;
      w_load.ctrl  = ID_Ctrl;
      if (!ID_Valid) begin
         w_load.ctrl = 6'd0;
         w_load.rd   = 5'd0;
      end
   end

   // One action per edge: flush beats stall beats hazard beats load
   always_comb begin
      w_act = ACT_LOAD;
      priority case (1'b1)
         Flush:    w_act = ACT_BUBBLE;
         Stall:    w_act = ACT_HOLD;
         w_hazard: w_act = ACT_BUBBLE;
         default:  w_act = ACT_LOAD;
      endcase
   end

   // Pipeline register contents
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ex <= '0;
      end else begin
         case (w_act)
            ACT_BUBBLE: r_ex <= '0;
            ACT_LOAD:   r_ex <= w_load;
            default:    r_ex <= r_ex;
         endcase
      end
   end

   // Saturating count of inserted bubbles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bubbles <= 16'd0;
      end else if (w_act == ACT_BUBBLE && r_bubbles != 16'hFFFF) begin
         r_bubbles <= r_bubbles + 16'd1;
      end
   end

   assign HazardStall  = w_hazard;
   assign BubbleCount  = r_bubbles;
   assign EX_Valid     = r_ex.valid;
   assign EX_PC        = r_ex.pc;
   assign EX_ReadData1 = r_ex.rd1;
   assign EX_ReadData2 = r_ex.rd2;
   assign EX_Imm       = r_ex.imm;
   assign EX_Rs1       = r_ex.rs1;
   assign EX_Rs2       = r_ex.rs2;
   assign EX_Rd        = r_ex.rd;
   assign EX_Funct     = r_ex.funct;
   assign EX_ALUOp     = r_ex.aluop;
   assign EX_Ctrl      = r_ex.ctrl;

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed steps,
// expected EX image and bubble count queued per edge.
module tb_id_ex_register;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            Stall;
   logic            Flush;
   logic            ID_Valid;
   logic [XLEN-1:0] ID_PC;
   logic [XLEN-1:0] ID_ReadData1;
   logic [XLEN-1:0] ID_ReadData2;
   logic [XLEN-1:0] ID_Imm;
   logic [4:0]      ID_Rs1;
   logic [4:0]      ID_Rs2;
   logic [4:0]      ID_Rd;
   logic [3:0]      ID_Funct;
   logic [1:0]      ID_ALUOp;
   logic [5:0]      ID_Ctrl;
   logic            EX_Valid;
   logic [XLEN-1:0] EX_PC;
   logic [XLEN-1:0] EX_ReadData1;
   logic [XLEN-1:0] EX_ReadData2;
   logic [XLEN-1:0] EX_Imm;
   logic [4:0]      EX_Rs1;
   logic [4:0]      EX_Rs2;
   logic [4:0]      EX_Rd;
   logic [3:0]      EX_Funct;
   logic [1:0]      EX_ALUOp;
   logic [5:0]      EX_Ctrl;
   logic            HazardStall;
   logic [15:0]     BubbleCount;

   always #5 clk = ~clk;

   id_ex_register #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .Stall        (Stall),
      .Flush        (Flush),
      .ID_Valid     (ID_Valid),
      .ID_PC        (ID_PC),
      .ID_ReadData1 (ID_ReadData1),
      .ID_ReadData2 (ID_ReadData2),
      .ID_Imm       (ID_Imm),
      .ID_Rs1       (ID_Rs1),
      .ID_Rs2       (ID_Rs2),
      .ID_Rd        (ID_Rd),
      .ID_Funct     (ID_Funct),
      .ID_ALUOp     (ID_ALUOp),
      .ID_Ctrl      (ID_Ctrl),
      .EX_Valid     (EX_Valid),
      .EX_PC        (EX_PC),
      .EX_ReadData1 (EX_ReadData1),
      .EX_ReadData2 (EX_ReadData2),
      .EX_Imm       (EX_Imm),
      .EX_Rs1       (EX_Rs1),
      .EX_Rs2       (EX_Rs2),
      .EX_Rd        (EX_Rd),
      .EX_Funct     (EX_Funct),
      .EX_ALUOp     (EX_ALUOp),
      .EX_Ctrl      (EX_Ctrl),
      .HazardStall  (HazardStall),
      .BubbleCount  (BubbleCount)
   );

   typedef struct packed {
      logic            v;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [3:0]      funct;
      logic [1:0]      aluop;
      logic [5:0]      ctrl;
   } ex_t;

   typedef struct packed {
      ex_t         ex;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sbq[$];
   ex_t         m_ex;
   logic [15:0] m_cnt;
   int          n_assert = 0;
   int          n_fail   = 0;

   function automatic ex_t dut_ex();
      return {EX_Valid, EX_PC, EX_ReadData1, EX_ReadData2, EX_Imm,
              EX_Rs1, EX_Rs2, EX_Rd, EX_Funct, EX_ALUOp, EX_Ctrl};
   endfunction

   function automatic ex_t id_img();
      ex_t e;
      e = {ID_Valid, ID_PC, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_Rs1, ID_Rs2, ID_Rd, ID_Funct, ID_ALUOp, ID_Ctrl};
      if (!ID_Valid) begin
         e.ctrl = 6'd0;
         e.rd   = 5'd0;
      end
      return e;
   endfunction

   function automatic logic m_hz();
      return m_ex.v & m_ex.ctrl[3] & (m_ex.rd != 5'd0) & ID_Valid
           & ((m_ex.rd == ID_Rs1) | (m_ex.rd == ID_Rs2));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ex(input string tag, input ex_t obs, input ex_t exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [63:0] pc,
                         input logic [63:0] r1, input logic [63:0] r2,
                         input logic [63:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [3:0] fn, input logic [1:0] op,
                         input logic [5:0] ctrl);
      ID_Valid     = v;
      ID_PC        = pc;
      ID_ReadData1 = r1;
      ID_ReadData2 = r2;
      ID_Imm       = imm;
      ID_Rs1       = rs1;
      ID_Rs2       = rs2;
      ID_Rd        = rd;
      ID_Funct     = fn;
      ID_ALUOp     = op;
      ID_Ctrl      = ctrl;
   endtask

   // Inputs already driven: predict, queue, clock, then compare
   task automatic step(input string tag);
      exp_t e;
      logic hz;
      #1;
      hz = m_hz();
      chk({tag, "_hz"}, {63'd0, HazardStall}, {63'd0, hz});
      e.ex  = m_ex;
      e.cnt = m_cnt;
      if (Flush || (!Stall && hz)) begin
         e.ex = '0;
         if (m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
      end else if (!Stall) begin
         e.ex = id_img();
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk_ex({tag, "_ex"}, dut_ex(), e.ex);
      chk({tag, "_cnt"}, {48'd0, BubbleCount}, {48'd0, e.cnt});
      m_ex  = e.ex;
      m_cnt = e.cnt;
   endtask

   initial begin
      reset_n = 1'b0;
      Stall   = 1'b0;
      Flush   = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_ex  = '0;
      m_cnt = 16'd0;
      #2;
      chk_ex("reset_ex", dut_ex(), '0);
      chk("reset_cnt", {48'd0, BubbleCount}, 64'd0);
      chk("reset_hz", {63'd0, HazardStall}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // plain R-type load
      set_id(1, 64'h1000, 64'hAAAA, 64'hBBBB, 64'h10, 5'd1, 5'd2, 5'd5,
             4'b1000, 2'b10, 6'b100000);
      step("load");
      chk("load_aluop", {62'd0, EX_ALUOp}, 64'd2);
      chk("load_funct", {60'd0, EX_Funct}, 64'h8);
      chk("load_rd", {59'd0, EX_Rd}, 64'd5);
      chk("load_valid", {63'd0, EX_Valid}, 64'd1);

      // ld x7 then a consumer of x7 on Rs2
      set_id(1, 64'h1004, 64'h2000, 64'h0, 64'h8, 5'd2, 5'd0, 5'd7,
             4'b0011, 2'b00, 6'b111001);
      step("ld");
      set_id(1, 64'h1008, 64'h11, 64'h22, 64'h0, 5'd3, 5'd7, 5'd9,
             4'b0000, 2'b10, 6'b100000);
      #1;
      chk("luse_hz_pre", {63'd0, HazardStall}, 64'd1);
      step("luse");
      chk("luse_valid", {63'd0, EX_Valid}, 64'd0);
      chk("luse_ctrl", {58'd0, EX_Ctrl}, 64'd0);
      chk("luse_cnt", {48'd0, BubbleCount}, 64'd1);
      chk("luse_hz_post", {63'd0, HazardStall}, 64'd0);
      step("luse_retry");

      // stall three edges with changing ID inputs
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 64'($urandom), 64'($urandom), 64'($urandom),
                64'($urandom), 5'd20, 5'd21, 5'($urandom_range(1, 31)),
                4'($urandom), 2'b10, 6'($urandom));
         step("stall");
      end
      chk("stall_pc", EX_PC, 64'h1008);
      chk("stall_cnt", {48'd0, BubbleCount}, 64'd1);
      Stall = 1'b0;
      set_id(1, 64'h2000, 64'h5, 64'h6, 64'h7, 5'd4, 5'd5, 5'd6,
             4'b0111, 2'b10, 6'b100001);
      step("release");
      chk("release_pc", EX_PC, 64'h2000);

      // stall together with a pending load-use hazard
      set_id(1, 64'h2004, 64'h3000, 64'h0, 64'h10, 5'd2, 5'd0, 5'd7,
             4'b0011, 2'b00, 6'b111001);
      step("ld2");
      set_id(1, 64'h2008, 64'h1, 64'h2, 64'h0, 5'd7, 5'd8, 5'd10,
             4'b0000, 2'b10, 6'b100000);
      Stall = 1'b1;
      step("st_hz1");
      step("st_hz2");
      chk("st_hz_flag", {63'd0, HazardStall}, 64'd1);
      chk("st_hz_cnt", {48'd0, BubbleCount}, 64'd1);
      Stall = 1'b0;
      step("st_hz_rel");
      chk("st_hz_rel_cnt", {48'd0, BubbleCount}, 64'd2);

      // flush and stall together
      step("pre_flush");
      Flush = 1'b1;
      Stall = 1'b1;
      step("flush_stall");
      chk("fs_cnt", {48'd0, BubbleCount}, 64'd3);
      chk("fs_valid", {63'd0, EX_Valid}, 64'd0);
      Flush = 1'b0;
      Stall = 1'b0;

      // load into x0 never hazards
      set_id(1, 64'h3000, 64'h9, 64'h0, 64'h4, 5'd1, 5'd0, 5'd0,
             4'b0011, 2'b00, 6'b111001);
      step("ld_x0");
      set_id(1, 64'h3004, 64'h1, 64'h2, 64'h0, 5'd0, 5'd0, 5'd11,
             4'b0000, 2'b10, 6'b100000);
      #1;
      chk("x0_hz", {63'd0, HazardStall}, 64'd0);
      step("x0_use");

      // invalid instruction is stored without side effects
      set_id(0, 64'h4000, 64'h1, 64'h2, 64'h3, 5'd1, 5'd2, 5'd12,
             4'b0101, 2'b10, 6'b101010);
      step("inval");
      chk("inval_ctrl", {58'd0, EX_Ctrl}, 64'd0);
      chk("inval_rd", {59'd0, EX_Rd}, 64'd0);
      chk("inval_pc", EX_PC, 64'h4000);

      // asynchronous reset between edges
      set_id(1, 64'h5000, 64'h77, 64'h88, 64'h99, 5'd1, 5'd2, 5'd13,
             4'b0000, 2'b10, 6'b100000);
      step("pre_rst");
      #2;
      reset_n = 1'b0;
      #1;
      chk_ex("arst_ex", dut_ex(), '0);
      chk("arst_cnt", {48'd0, BubbleCount}, 64'd0);
      chk("arst_hz", {63'd0, HazardStall}, 64'd0);
      m_ex  = '0;
      m_cnt = 16'd0;
      @(negedge clk);
      reset_n = 1'b1;
      step("post_rst");

      // saturation over 65540 flush edges
      Flush = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", {48'd0, BubbleCount}, 64'hFFFE);
      repeat (6) @(posedge clk);
      #1;
      chk("sat_ffff", {48'd0, BubbleCount}, 64'hFFFF);
      chk("sat_valid", {63'd0, EX_Valid}, 64'd0);
      m_ex  = '0;
      m_cnt = 16'hFFFF;
      step("sat_hold");
      Flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter XLEN, default 64, datapath width of PC, register operands and immediate.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Stall  input  1  downstream hold request; register contents are frozen.
REQ-005 Flush  input  1  branch/jump squash; next EX contents become a bubble.
REQ-006 ID_Valid  input  1  ID stage holds a real instruction.
REQ-007 ID_PC, ID_ReadData1, ID_ReadData2, ID_Imm  input  XLEN each  decoded operands.
REQ-008 ID_Rs1, ID_Rs2, ID_Rd  input  5 each  register addresses.
REQ-009 ID_Funct  input  4  {funct7[5], funct3}, passed unmodified to the ALU control stage.
REQ-010 ID_ALUOp  input  2  ALU class: 00 add, 01 subtract/branch, 10 R-type decode.
REQ-011 ID_Ctrl  input  6  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc}.
REQ-012 EX_Valid, EX_PC, EX_ReadData1, EX_ReadData2, EX_Imm, EX_Rs1, EX_Rs2, EX_Rd, EX_Funct, EX_ALUOp, EX_Ctrl  output  same widths  registered copies.
REQ-013 HazardStall  output  1  load-use hazard; upstream PC and IF/ID hold while asserted.
REQ-014 BubbleCount  output  16  number of bubbles inserted since reset.

Function
REQ-015 HazardStall SHALL be combinational from registered state and ID inputs: EX_Valid & EX_Ctrl[MemRead] & (EX_Rd != 0) & ID_Valid & ((EX_Rd == ID_Rs1) | (EX_Rd == ID_Rs2)).
REQ-016 Each rising edge SHALL perform exactly one action, in priority order: Flush -> bubble; else Stall -> hold; else HazardStall -> bubble; else load.
REQ-017 Load: every EX_ output SHALL take its ID_ counterpart one cycle later (latency 1).
REQ-018 Hold: every EX_ output and BubbleCount SHALL retain its value.
REQ-019 Bubble: EX_Valid=0, EX_Ctrl=0, EX_ALUOp=00, EX_Funct=0, EX_Rd=0; data/address fields SHALL be zeroed.
REQ-020 A loaded instruction with ID_Valid=0 SHALL be stored with EX_Ctrl forced to 0 and EX_Rd forced to 0.
REQ-021 BubbleCount SHALL increment by 1 on each bubble action and saturate at 16'hFFFF without wrap.
REQ-022 Flush and Stall asserted together SHALL produce a bubble (flush wins).
REQ-023 Stall and HazardStall asserted together SHALL hold; HazardStall stays asserted, no bubble counted.
REQ-024 An instruction with EX_Ctrl=0 (bubble or invalid) SHALL never cause HazardStall.
REQ-025 Rd = x0 SHALL never cause HazardStall.

Reset
REQ-026 reset_n low SHALL asynchronously force all EX_ outputs to 0, EX_Valid=0, BubbleCount=0, and hence HazardStall=0.
REQ-027 Reset asserted mid-operation SHALL discard the held instruction; first edge after deassertion performs a normal REQ-016 action.

Verification
REQ-028 Load: ID_Valid=1, ID_ALUOp=10, ID_Funct=4'b1000, ID_Rd=5, Ctrl RegWrite=1 -> next cycle EX_ALUOp=10, EX_Funct=1000, EX_Rd=5, EX_Valid=1.
REQ-029 Load-use: EX holds ld x7 (MemRead=1, Rd=7); ID Rs2=7 -> HazardStall=1, next edge EX_Valid=0, EX_Ctrl=0, BubbleCount 0->1, HazardStall then 0.
REQ-030 Stall: Stall=1 for 3 cycles with changing ID inputs -> EX outputs and BubbleCount unchanged; release -> current ID inputs load.
REQ-031 Flush+Stall: both high one edge -> bubble, BubbleCount +1; x0 case: EX Rd=0, MemRead=1, ID Rs1=0 -> HazardStall=0.
REQ-032 Saturation: 65540 consecutive Flush edges -> BubbleCount=16'hFFFF, no wrap.
REQ-033 Async reset: drop reset_n between edges with EX_Valid=1 -> all outputs 0 immediately, before next clk edge.
